// File: rtl/regdump_streamer.sv
// regdump_streamer: walks the register file through the debug read port and
// streams each register as an ASCII line "xNN: 0xHHHHHHHH\r\n" over a
// valid/ready byte interface.
// Optional feature macro: REGDUMP_HEADER_EN (prefix each dump with "REGS\r\n").
module regdump_streamer #(
   parameter int NUM_REGS = 32,
   parameter int ADDR_W   = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] reg_addr,
   input  logic [31:0]       reg_data,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_ready
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
`ifdef REGDUMP_HEADER_EN
      HDR   = 3'd1,
`endif
      FETCH = 3'd2,
      LATCH = 3'd3,
      SEND  = 3'd4,
      DONE  = 3'd5
   } state_t;

   state_t            state, nstate;
   logic [ADDR_W-1:0] idx;
   logic [4:0]        cnt;
   logic [31:0]       snap;
   logic              xfer;
   logic              last_reg;
   logic [5:0]        idx6;
   logic [1:0]        tens;
   logic [3:0]        units;
   logic [2:0]        nsel;
   logic [3:0]        nib;

   function automatic logic [7:0] hex_ascii(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
   endfunction

   assign xfer     = tx_valid && tx_ready;
   assign last_reg = (idx == ADDR_W'(NUM_REGS - 1));

   // Decimal digits of the index and the hex nibble selected by the byte counter
   always_comb begin
      idx6  = 6'(idx);
      if (idx6 >= 6'd30)      tens = 2'd3;
      else if (idx6 >= 6'd20) tens = 2'd2;
      else if (idx6 >= 6'd10) tens = 2'd1;
      else                    tens = 2'd0;
      units = 4'(idx6 - 6'(tens) * 6'd10);
      // bytes 7..14 carry nibbles 7..0 (MSB first)
      nsel  = 3'(5'd14 - cnt);
      nib   = 4'(snap >> {nsel, 2'b00});
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= nstate;
   end

   // Next-state and output decode
   always_comb begin
      nstate   = state;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      busy     = (state != IDLE) && (state != DONE);
      done     = (state == DONE);
      reg_addr = idx;
      case (state)
         IDLE: begin
            if (start) begin
`ifdef REGDUMP_HEADER_EN
               nstate = HDR;
`else
               nstate = FETCH;
`endif
            end
         end
`ifdef REGDUMP_HEADER_EN
         HDR: begin
            tx_valid = 1'b1;
            case (cnt)
               5'd0:    tx_data = 8'h52;
               5'd1:    tx_data = 8'h45;
               5'd2:    tx_data = 8'h47;
               5'd3:    tx_data = 8'h53;
               5'd4:    tx_data = 8'h0D;
               default: tx_data = 8'h0A;
            endcase
            if (xfer && cnt == 5'd5) nstate = FETCH;
         end
`endif
         FETCH: nstate = LATCH;
         LATCH: nstate = SEND;
         SEND: begin
            tx_valid = 1'b1;
            case (cnt)
               5'd0:    tx_data = 8'h78;
               5'd1:    tx_data = 8'h30 + {6'd0, tens};
               5'd2:    tx_data = 8'h30 + {4'd0, units};
               5'd3:    tx_data = 8'h3A;
               5'd4:    tx_data = 8'h20;
               5'd5:    tx_data = 8'h30;
               5'd6:    tx_data = 8'h78;
               5'd15:   tx_data = 8'h0D;
               5'd16:   tx_data = 8'h0A;
               default: tx_data = hex_ascii(nib);
            endcase
            if (xfer && cnt == 5'd16) nstate = last_reg ? DONE : FETCH;
         end
         DONE:    nstate = IDLE;
         default: nstate = IDLE;
      endcase
   end

   // Index, byte counter and line snapshot
   always_ff @(posedge clk) begin
      if (reset) begin
         idx  <= '0;
         cnt  <= '0;
         snap <= '0;
      end else begin
         case (state)
            IDLE: begin
               idx <= '0;
               cnt <= '0;
            end
`ifdef REGDUMP_HEADER_EN
            HDR: if (xfer) cnt <= (cnt == 5'd5) ? 5'd0 : cnt + 5'd1;
`endif
            LATCH: snap <= reg_data;
            SEND: begin
               if (xfer) begin
                  if (cnt == 5'd16) begin
                     cnt <= '0;
                     if (!last_reg) idx <= idx + ADDR_W'(1);
                  end else begin
                     cnt <= cnt + 5'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
